gtx_link_ctl: RTL
=================

# gtx_link_ctl

Link bring-up and supervision controller for the single-lane GTX transceiver. It runs in the system clock domain and sequences the transceiver's soft resets. It waits for the TX/RX reset state machines to finish, confirms comma alignment, then monitors receive errors and optical loss. When the link degrades it retries bring-up, and after repeated failures it parks in a fault hold.

## Interface
Parameters:
- RST_CYCLES, 32: cycles soft_reset_o is held asserted per attempt
- DONE_TIMEOUT, 1048576: max cycles to wait for both reset-done flags
- ALIGN_TIMEOUT, 65536: max cycles to wait for comma detection
- ERR_WINDOW, 65536: error-rate observation window length in cycles
- ERR_MAX, 15: errors tolerated per window; exceeding it drops the link
- MAX_RETRY, 8: consecutive failed attempts before FAULT
- FAULT_HOLD, 1048576: cycles spent in FAULT before restarting

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; one clock, asynchronous assert, active-low
- sfp_los_i  in  1  SFP loss-of-signal, asynchronous
- tx_done_i  in  1  GTX TX reset FSM done, asynchronous
- rx_done_i  in  1  GTX RX reset FSM done, asynchronous
- rx_comma_i  in  1  level from RX domain, high while comma K-chars are received
- rx_err_i  in  1  level from RX domain, disparity or not-in-table error
- soft_reset_o  out  1  drives GTX soft TX/RX resets
- link_up_o  out  1  link usable
- state_o  out  3  current state encoding
- retry_cnt_o  out  4  consecutive failed attempts, saturating
- err_cnt_o  out  16  total rising edges of rx_err in UP, saturating at 16'hFFFF

## Operation
- All five inputs pass through 2-FF synchronizers before use. rx_err is edge-detected after the synchronizer; each rising edge counts as one error.
- States (state_o): RESET=0, WAIT_DONE=1, ALIGN=2, UP=3, FAULT=4.
- RESET: soft_reset_o=1 for RST_CYCLES cycles, then go to WAIT_DONE.
- WAIT_DONE: when tx_done and rx_done are both high, go to ALIGN. After DONE_TIMEOUT cycles, the attempt fails.
- ALIGN: rx_comma high for 4 consecutive cycles moves to UP and clears retry_cnt. After ALIGN_TIMEOUT cycles, or if either done flag drops, the attempt fails.
- A failed attempt increments retry_cnt. If the new value equals MAX_RETRY, go to FAULT; otherwise go to RESET.
- UP: link_up_o=1. The window counter runs; errors in the current window are counted separately from err_cnt.
  - Window error count > ERR_MAX, or tx_done/rx_done dropping: go to RESET. retry_cnt is unchanged.
  - At window end the window error count clears.
  - err_cnt is cleared only by rst_n_i.
- FAULT: soft_reset_o=1 for the whole FAULT_HOLD period. Then clear retry_cnt and go to RESET.
- Every state counter clears on state entry.

## Timing
- Reset values: state RESET, soft_reset_o=1, link_up_o=0, retry_cnt_o=0, err_cnt_o=0, state_o=0, all counters 0.
- All outputs are registered and reflect the new state in the cycle after the transition decision.
- Input-to-decision latency is 2 cycles (synchronizer), plus 1 cycle for the rx_err edge detector.
- RESET lasts exactly RST_CYCLES cycles, and soft_reset_o is high for exactly those cycles. On rst_n_i release the first RESET visit still lasts a full RST_CYCLES.
- Simultaneous events in UP: the error-threshold drop takes priority over the window-end clear. An error arriving on the last window cycle counts in the ending window.
- Asynchronous reset mid-operation immediately returns every output to its reset value.
- Counters are sized with $clog2 of each parameter and saturate, never wrap.

## Configuration
- GTX_LINK_CTL_LOS_EN defined:
  - sfp_los high forces FAULT→RESET-equivalent behaviour: from any state except RESET, go to RESET without incrementing retry_cnt.
  - While LOS is high, the block stays in RESET (soft_reset_o=1, timer frozen at 0).
- Undefined: the sfp_los_i synchronizer is removed and the input is ignored.

## Structure
- Package gtx_link_pkg: state enum typedef (3-bit, encodings above), COMMA_RUN=4 constant, err_cnt width constant.
- Sub-module sync_2ff (parameterised width) handles the input synchronizers. A single instance covers all five inputs.

## Test plan
- Bring-up (RST_CYCLES=4, tx_done/rx_done high at cycle 10, rx_comma high from cycle 20) → soft_reset_o high for exactly 4 cycles, state reaches UP (3), link_up_o=1, retry_cnt_o=0.
- DONE timeout (DONE_TIMEOUT=50, MAX_RETRY=3, done flags held low) → three RESET/WAIT_DONE loops, retry_cnt_o 1,2,3, then state 4 with soft_reset_o=1. After FAULT_HOLD, state 0 and retry_cnt_o=0.
- Error threshold (ERR_MAX=2, ERR_WINDOW=100, in UP) → 3 rx_err pulses within one window cause a drop to RESET, err_cnt_o=3. 2 pulses per window keep the link UP.
- Window boundary → 2 errors, window end, then 2 more errors keep the link UP, with err_cnt_o=4.
- LOS (macro defined) → sfp_los_i high in UP gives link_up_o=0 and state 0 within 3 cycles. The block stays in RESET until LOS falls, then bring-up completes. With the macro undefined, LOS has no effect.
- Async reset asserted in UP with err_cnt_o=5 → all outputs return to reset values in the same cycle, without a clock edge.

Source files
------------

// File: rtl/gtx_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gtx_link_pkg
// Description : Shared types and constants for the GTX link controller:
//               state encoding, comma run length, error counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package gtx_link_pkg;

    // Controller states; the encoding is visible on state_o
    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_ALIGN     = 3'd2,
        ST_UP        = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Consecutive comma cycles required to declare alignment
    localparam int c_COMMA_RUN = 4;

    // Width of the lifetime error counter
    localparam int c_ERR_CNT_W = 16;

    // Largest of four values, used to size the shared state timer
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer bank for asynchronous level inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two register stages give metastability time to resolve
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/gtx_link_ctl.sv
`default_nettype none
// ============================================================================
// Module      : gtx_link_ctl
// Description : GTX single-lane link bring-up and supervision controller.
//               Sequences soft resets, waits for reset-done, confirms comma
//               alignment, monitors error rate, retries and parks in FAULT.
//               Optional macro GTX_LINK_CTL_LOS_EN enables SFP loss-of-signal
//               handling; without it sfp_los_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module gtx_link_ctl
    import gtx_link_pkg::*;
#(
    parameter int RST_CYCLES    = 32,
    parameter int DONE_TIMEOUT  = 1048576,
    parameter int ALIGN_TIMEOUT = 65536,
    parameter int ERR_WINDOW    = 65536,
    parameter int ERR_MAX       = 15,
    parameter int MAX_RETRY     = 8,
    parameter int FAULT_HOLD    = 1048576
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   sfp_los_i,
    input  logic                   tx_done_i,
    input  logic                   rx_done_i,
    input  logic                   rx_comma_i,
    input  logic                   rx_err_i,
    output logic                   soft_reset_o,
    output logic                   link_up_o,
    output logic [2:0]             state_o,
    output logic [3:0]             retry_cnt_o,
    output logic [c_ERR_CNT_W-1:0] err_cnt_o
);

    // One timer serves every timed state, so it is sized for the longest one
    localparam int c_TMR_MAX = max_of4(RST_CYCLES, DONE_TIMEOUT, ALIGN_TIMEOUT, FAULT_HOLD);
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_WIN_W   = $clog2(ERR_WINDOW + 1);
    localparam int c_WERR_W  = $clog2(ERR_MAX + 2);
    localparam int c_RUN_W   = $clog2(c_COMMA_RUN + 1);

    localparam logic [c_TMR_W-1:0]  c_RST_LAST   = c_TMR_W'(RST_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_DONE_LAST  = c_TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0]  c_ALIGN_LAST = c_TMR_W'(ALIGN_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0]  c_HOLD_LAST  = c_TMR_W'(FAULT_HOLD - 1);
    localparam logic [c_WIN_W-1:0]  c_WIN_LAST   = c_WIN_W'(ERR_WINDOW - 1);
    localparam logic [c_WERR_W-1:0] c_ERR_MAX_V  = c_WERR_W'(ERR_MAX);
    localparam logic [c_RUN_W-1:0]  c_RUN_LAST   = c_RUN_W'(c_COMMA_RUN - 1);
    localparam logic [3:0]          c_RETRY_MAX  = 4'(MAX_RETRY);

`ifdef GTX_LINK_CTL_LOS_EN
    localparam int c_SYNC_W = 5;
`else
    localparam int c_SYNC_W = 4;
`endif

    logic [c_SYNC_W-1:0] w_async;
    logic [c_SYNC_W-1:0] w_sync;
    logic                w_tx;
    logic                w_rx;
    logic                w_comma;
    logic                w_err_s;
    logic                w_los;
    logic                w_done_ok;

`ifdef GTX_LINK_CTL_LOS_EN
    assign w_async = {sfp_los_i, rx_err_i, rx_comma_i, rx_done_i, tx_done_i};
    assign w_los   = w_sync[4];
`else
    logic w_unused_los;
    assign w_unused_los = sfp_los_i;
    assign w_async      = {rx_err_i, rx_comma_i, rx_done_i, tx_done_i};
    assign w_los        = 1'b0;
`endif

    sync_2ff #(
        .WIDTH (c_SYNC_W)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (w_async),
        .q_o     (w_sync)
    );

    assign w_tx      = w_sync[0];
    assign w_rx      = w_sync[1];
    assign w_comma   = w_sync[2];
    assign w_err_s   = w_sync[3];
    assign w_done_ok = w_tx & w_rx;

    state_t                  r_state;
    state_t                  w_next;
    logic [c_TMR_W-1:0]      r_tmr;
    logic [c_RUN_W-1:0]      r_run;
    logic [c_WIN_W-1:0]      r_win;
    logic [c_WERR_W-1:0]     r_werr;
    logic [c_WERR_W-1:0]     w_werr_next;
    logic [3:0]              r_retry;
    logic [3:0]              w_retry_inc;
    logic [c_ERR_CNT_W-1:0]  r_err_cnt;
    logic                    r_err_d;
    logic                    r_err_rise;
    logic                    r_soft_reset;
    logic                    r_link_up;
    logic                    w_fail;
    logic                    w_retry_clr;
    logic                    w_los_hold;

    assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
    assign w_werr_next = (r_err_rise && (r_werr != '1)) ? r_werr + c_WERR_W'(1) : r_werr;

    // Next-state decision, attempt failure and retry bookkeeping
    always_comb begin
        w_next      = r_state;
        w_fail      = 1'b0;
        w_retry_clr = 1'b0;
        w_los_hold  = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (w_los) begin
                    w_los_hold = 1'b1;
                end else if (r_tmr == c_RST_LAST) begin
                    w_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (w_done_ok) begin
                    w_next = ST_ALIGN;
                end else if (r_tmr == c_DONE_LAST) begin
                    w_fail = 1'b1;
                end
            end
            ST_ALIGN: begin
                if (!w_done_ok) begin
                    w_fail = 1'b1;
                end else if (w_comma && (r_run == c_RUN_LAST)) begin
                    w_next      = ST_UP;
                    w_retry_clr = 1'b1;
                end else if (r_tmr == c_ALIGN_LAST) begin
                    w_fail = 1'b1;
                end
            end
            ST_UP: begin
                // Threshold check uses the count including this cycle's error
                if ((w_werr_next > c_ERR_MAX_V) || !w_done_ok) begin
                    w_next = ST_RESET;
                end
            end
            ST_FAULT: begin
                if (r_tmr == c_HOLD_LAST) begin
                    w_next      = ST_RESET;
                    w_retry_clr = 1'b1;
                end
            end
            default: begin
                w_next = ST_RESET;
            end
        endcase

        if (w_fail) begin
            w_next = (w_retry_inc == c_RETRY_MAX) ? ST_FAULT : ST_RESET;
        end

        // Loss of signal restarts bring-up without charging a retry
        if (w_los && (r_state != ST_RESET)) begin
            w_next      = ST_RESET;
            w_fail      = 1'b0;
            w_retry_clr = 1'b0;
        end
    end

    // State register and registered outputs aligned with it
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_RESET;
            r_soft_reset <= 1'b1;
            r_link_up    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_soft_reset <= (w_next == ST_RESET) || (w_next == ST_FAULT);
            r_link_up    <= (w_next == ST_UP);
        end
    end

    // Shared state timer: clears on entry, frozen at zero while LOS holds RESET
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmr <= '0;
        end else if ((w_next != r_state) || w_los_hold) begin
            r_tmr <= '0;
        end else if (r_tmr != '1) begin
            r_tmr <= r_tmr + c_TMR_W'(1);
        end
    end

    // Consecutive comma counter, only meaningful while staying in ALIGN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run <= '0;
        end else if ((r_state == ST_ALIGN) && (w_next == ST_ALIGN) && w_comma) begin
            if (r_run != '1) r_run <= r_run + c_RUN_W'(1);
        end else begin
            r_run <= '0;
        end
    end

    // Error-rate window: window position and per-window error count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_win  <= '0;
            r_werr <= '0;
        end else if ((r_state == ST_UP) && (w_next == ST_UP)) begin
            if (r_win == c_WIN_LAST) begin
                r_win  <= '0;
                r_werr <= '0;
            end else begin
                r_win  <= r_win + c_WIN_W'(1);
                r_werr <= w_werr_next;
            end
        end else begin
            r_win  <= '0;
            r_werr <= '0;
        end
    end

    // rx_err rising-edge detector, registered to give a clean one-cycle pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_d    <= 1'b0;
            r_err_rise <= 1'b0;
        end else begin
            r_err_d    <= w_err_s;
            r_err_rise <= w_err_s & ~r_err_d;
        end
    end

    // Lifetime error count while UP, saturating
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_cnt <= '0;
        end else if ((r_state == ST_UP) && r_err_rise && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + c_ERR_CNT_W'(1);
        end
    end

    // Consecutive failed attempts, saturating
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_retry <= '0;
        end else if (w_retry_clr) begin
            r_retry <= '0;
        end else if (w_fail) begin
            r_retry <= w_retry_inc;
        end
    end

    assign soft_reset_o = r_soft_reset;
    assign link_up_o    = r_link_up;
    assign state_o      = r_state;
    assign retry_cnt_o  = r_retry;
    assign err_cnt_o    = r_err_cnt;

endmodule
`default_nettype wire
